// File: rtl/pipe_scaler.sv
// -----------------------------------------------------------------------------
// pipe_scaler
//
// Multi-channel scaling pipeline with valid/ready flow control on both sides.
// Each accepted beat carries NCH data words plus one unsigned coefficient.
// Words that are all-zeros or all-ones are marker words and pass through
// untouched. Every other word is multiplied by the coefficient. The result
// travels through a DEPTH-stage elastic pipeline that absorbs backpressure
// without dropping or duplicating beats.
//
// Optional feature macro: PIPE_SCALER_SAT_EN
//   defined     : products above 2^DW-1 clamp to all-ones and raise o_sat
//   not defined : products wrap to their low DW bits; o_sat is tied to 0 and
//                 no overflow compare logic exists
//
// Parameters
//   NCH    number of channels (>=1)
//   DW     data word width per channel (>=2)
//   CW     coefficient width (>=1)
//   DEPTH  pipeline stages = latency and capacity in beats (>=1)
//
// Ports
//   clk      in   clock, all logic on the rising edge
//   rst      in   synchronous active-high reset
//   i_valid  in   upstream beat valid
//   o_ready  out  block can accept a beat this cycle
//   i_cf     in   coefficient [CW], sampled with the beat
//   i_data   in   channel words [NCH*DW], channel c at [c*DW +: DW]
//   o_valid  out  output beat valid
//   i_ready  in   downstream accepts the output beat
//   o_data   out  scaled words [NCH*DW], same packing as i_data
//   o_sat    out  per-channel saturation flags [NCH], aligned with o_data
// -----------------------------------------------------------------------------
module pipe_scaler #(
   parameter int NCH   = 2,
   parameter int DW    = 16,
   parameter int CW    = 2,
   parameter int DEPTH = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_valid,
   output logic                o_ready,
   input  logic [CW-1:0]       i_cf,
   input  logic [NCH*DW-1:0]   i_data,
   output logic                o_valid,
   input  logic                i_ready,
   output logic [NCH*DW-1:0]   o_data,
   output logic [NCH-1:0]      o_sat
);

   // ---------------------------------------------------------------------------
   // Per-channel scaling, evaluated combinationally on the incoming beat
   // ---------------------------------------------------------------------------
   logic [NCH*DW-1:0] scaled;
`ifdef PIPE_SCALER_SAT_EN
   logic [NCH-1:0]    scaled_sat;
`endif

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic [DW-1:0] word;
      logic          marker;

      assign word   = i_data[c*DW +: DW];
      assign marker = (word == '0) || (word == '1);

`ifdef PIPE_SCALER_SAT_EN
      // Full-width product; any bit above the word width means overflow.
      logic [DW+CW-1:0] prod;
      logic             ovf;

      assign prod = {{CW{1'b0}}, word} * {{DW{1'b0}}, i_cf};
      assign ovf  = |prod[DW+CW-1:DW];

      assign scaled[c*DW +: DW] = marker ? word :
                                  ovf    ? {DW{1'b1}} : prod[DW-1:0];
      assign scaled_sat[c]      = !marker && ovf;
`else
      // Only the low DW bits survive, so the product is formed at DW width.
      logic [DW-1:0] prod_lo;

      assign prod_lo            = word * DW'(i_cf);
      assign scaled[c*DW +: DW] = marker ? word : prod_lo;
`endif
   end

   // ---------------------------------------------------------------------------
   // Elastic pipeline
   //
   // Stage k may load whenever some stage at or after k has room, or the
   // output is being taken. Evaluating that directly from the valid bits keeps
   // the ready path a flat AND/OR instead of a ripple through the stages.
   // ---------------------------------------------------------------------------
   logic [DEPTH-1:0]  st_valid;
   logic [NCH*DW-1:0] st_data [DEPTH];
`ifdef PIPE_SCALER_SAT_EN
   logic [NCH-1:0]    st_sat  [DEPTH];
`endif

   logic              adv       [DEPTH];
   logic              src_valid [DEPTH];
   logic [NCH*DW-1:0] src_data  [DEPTH];
`ifdef PIPE_SCALER_SAT_EN
   logic [NCH-1:0]    src_sat   [DEPTH];
`endif

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      assign adv[k] = i_ready || !(&st_valid[DEPTH-1:k]);

      if (k == 0) begin : g_head
         assign src_valid[k] = i_valid;
         assign src_data[k]  = scaled;
`ifdef PIPE_SCALER_SAT_EN
         assign src_sat[k]   = scaled_sat;
`endif
      end else begin : g_body
         assign src_valid[k] = st_valid[k-1];
         assign src_data[k]  = st_data[k-1];
`ifdef PIPE_SCALER_SAT_EN
         assign src_sat[k]   = st_sat[k-1];
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_valid <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            st_data[k] <= '0;
`ifdef PIPE_SCALER_SAT_EN
            st_sat[k]  <= '0;
`endif
         end
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            if (adv[k]) begin
               st_valid[k] <= src_valid[k];
               // Payload only moves with a real beat, so bubbles leave the
               // last held value in place rather than toggling the datapath.
               if (src_valid[k]) begin
                  st_data[k] <= src_data[k];
`ifdef PIPE_SCALER_SAT_EN
                  st_sat[k]  <= src_sat[k];
`endif
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign o_ready = adv[0];
   assign o_valid = st_valid[DEPTH-1];
   assign o_data  = st_data[DEPTH-1];
`ifdef PIPE_SCALER_SAT_EN
   assign o_sat   = st_sat[DEPTH-1];
`else
   assign o_sat   = '0;
`endif

endmodule
